// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: byte transaction sequencer between a TX/RX FIFO pair and the SPI master.
// Optional WAIT watchdog and sticky err flag are built when `SPI_XFER_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for en, TX data and RX space
// LAUNCH | start pulse to the master, config and din_m already latched
// WAIT   | byte in flight, waiting for done_m (or the watchdog)
// GAP    | enforced idle time before the next launch

module spi_xfer_ctrl #(
    parameter int DEPTH   = 8,
    parameter int GAP_CYC = 4,
    parameter int TO_CYC  = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tx_wr,
    input  logic [7:0]  tx_data,
    output logic        tx_full,
    input  logic        rx_rd,
    output logic [7:0]  rx_data,
    output logic        rx_empty,
    input  logic [15:0] cfg_dvsr,
    input  logic        cfg_cpol,
    input  logic        cfg_cpha,
    output logic        start,
    output logic [7:0]  din_m,
    output logic [15:0] dvsr,
    output logic        cpol,
    output logic        cpha,
    input  logic        done_m,
    input  logic [7:0]  dout_m,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE      = (AW + 1)'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t state, state_nxt;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_count;
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_count;
    logic [AW:0]   rx_resv;
    logic [GW-1:0] gap_cnt;

    logic tx_push, tx_pop, rx_push, rx_pop;
    logic inflight, can_launch, launch, timeout;

    assign tx_full  = (tx_count == FULL);
    assign rx_empty = (rx_count == '0);
    assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rptr];

    assign tx_push  = tx_wr && !tx_full;
    assign tx_pop   = launch;
    assign rx_pop   = rx_rd && !rx_empty;

    // Bytes already launched but not yet written back hold an RX slot.
    assign inflight   = (state == LAUNCH) || (state == WAIT);
    assign rx_resv    = rx_count + {{AW{1'b0}}, inflight};
    assign can_launch = en && (tx_count != '0) && (rx_resv < FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (can_launch) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (done_m || timeout) state_nxt = GAP;
            GAP:     if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start   = (state == LAUNCH);
        launch  = (state == IDLE) && can_launch;
        rx_push = (state == WAIT) && done_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if ((state == WAIT) && (state_nxt == GAP)) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= tx_data;
        if (rx_push) rx_mem[rx_wptr] <= dout_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            unique case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + ONE;
                2'b01:   tx_count <= tx_count - ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            unique case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + ONE;
                2'b01:   rx_count <= rx_count - ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Master-facing byte and config only move on the launch edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_m <= 8'h00;
            dvsr  <= 16'h0000;
            cpol  <= 1'b0;
            cpha  <= 1'b0;
        end else if (launch) begin
            din_m <= tx_mem[tx_rptr];
            dvsr  <= cfg_dvsr;
            cpol  <= cfg_cpol;
            cpha  <= cfg_cpha;
        end
    end

`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC - 1);

    logic [TW-1:0] wd_cnt;

    assign timeout = (state == WAIT) && !done_m && (wd_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == LAUNCH) begin
            wd_cnt <= TO_LOAD;
        end else if ((state == WAIT) && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - TW'(1);
        end
    end

    // A new timeout wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    localparam int unused_to_cyc = TO_CYC;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: vector table, directed corner sequences and a
// randomized run against a queue-based model of the byte stream.

module tb_spi_xfer_ctrl;

    localparam int DEPTH   = 8;
    localparam int GAP_CYC = 4;
    localparam int TO_CYC  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, tx_wr = 1'b0, rx_rd = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_full, rx_empty, start, busy, err;
    logic [7:0]  rx_data, din_m;
    logic [15:0] cfg_dvsr = 16'd0, dvsr;
    logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cpol, cpha;
    logic        done_m = 1'b0, err_clr = 1'b0;
    logic [7:0]  dout_m = 8'h00;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .en(en), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .cfg_dvsr(cfg_dvsr),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .start(start), .din_m(din_m), .dvsr(dvsr),
        .cpol(cpol), .cpha(cpha), .done_m(done_m), .dout_m(dout_m), .busy(busy), .err(err),
        .err_clr(err_clr)
    );

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rd;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_busy;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // slave model: answers each start after slave_lat cycles with din ^ slave_mask
    bit         slave_on = 1'b0;
    int         slave_lat = 3;
    logic [7:0] slave_mask = 8'h00;
    int         sl_cnt = 0;
    logic [7:0] sl_byte = 8'h00;
    bit         saw_start = 1'b0;

    logic [7:0] exp_rx[$];
    logic [7:0] acc_q[$];
    logic [7:0] st_byte[$];
    int         st_cyc[$];
    int         done_cyc[$];

    logic [7:0]  exp_din;
    logic [15:0] exp_dvsr;
    logic        exp_cpol, exp_cpha;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        saw_start = 1'b0;
        if (done_m) exp_rx.push_back(dout_m);
        done_m = 1'b0;
        if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                done_m = 1'b1;
                dout_m = sl_byte ^ slave_mask;
                done_cyc.push_back(cyc);
            end
        end
        if (start) begin
            saw_start = 1'b1;
            st_cyc.push_back(cyc);
            st_byte.push_back(din_m);
            if (slave_on) begin
                sl_cnt  = slave_lat;
                sl_byte = din_m;
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] d);
        tx_wr = 1'b1;
        tx_data = d;
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int bound, input string name);
        int k = 0;
        while (st_cyc.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk(name, st_cyc.size(), n);
    endtask

    task automatic wait_dones(input int n, input int bound, input string name);
        int k = 0;
        while (done_cyc.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk(name, done_cyc.size(), n);
        tick();
    endtask

    task automatic tb_clear();
        sl_cnt = 0;
        done_m = 1'b0;
        exp_rx.delete();
        acc_q.delete();
        st_byte.delete();
        st_cyc.delete();
        done_cyc.delete();
        exp_din  = 8'h00;
        exp_dvsr = 16'h0000;
        exp_cpol = 1'b0;
        exp_cpha = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"},    start,    1'b0);
        chk({tag, "_din_m"},    din_m,    8'h00);
        chk({tag, "_dvsr"},     dvsr,     16'h0000);
        chk({tag, "_cpol"},     cpol,     1'b0);
        chk({tag, "_cpha"},     cpha,     1'b0);
        chk({tag, "_busy"},     busy,     1'b0);
        chk({tag, "_err"},      err,      1'b0);
        chk({tag, "_tx_full"},  tx_full,  1'b0);
        chk({tag, "_rx_empty"}, rx_empty, 1'b1);
        chk({tag, "_rx_data"},  rx_data,  8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tb_clear();
        ticks(2);
        rst = 1'b1;
    endtask

    // one randomized cycle: drive, advance, then compare against the queue model
    task automatic model_step(input bit wr_req, input bit rd_req);
        tx_wr   = wr_req;
        tx_data = 8'($urandom);
        if (wr_req && acc_q.size() < DEPTH) acc_q.push_back(tx_data);
        rx_rd = rd_req;
        if (rd_req && exp_rx.size() > 0) void'(exp_rx.pop_front());
        tick();
        tx_wr = 1'b0;
        rx_rd = 1'b0;
        if (saw_start) begin
            if (acc_q.size() == 0) begin
                chk("rnd_unexpected_start", 32'd1, 32'd0);
            end else begin
                exp_din = acc_q.pop_front();
            end
            exp_dvsr = cfg_dvsr;
            exp_cpol = cfg_cpol;
            exp_cpha = cfg_cpha;
            chk("rnd_start_busy", busy, 1'b1);
            if (done_cyc.size() > 0)
                chk("rnd_gap", ((cyc - done_cyc[$]) >= GAP_CYC + 3), 1'b1);
        end
        chk("rnd_din_m", din_m, exp_din);
        chk("rnd_dvsr", dvsr, exp_dvsr);
        chk("rnd_cpol", cpol, exp_cpol);
        chk("rnd_cpha", cpha, exp_cpha);
        chk("rnd_tx_full", tx_full, (acc_q.size() == DEPTH));
        chk("rnd_rx_empty", rx_empty, (exp_rx.size() == 0));
        if (exp_rx.size() > 0) chk("rnd_rx_data", rx_data, exp_rx[0]);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   snap;
        int   s;

        // en=0: fill TX, overflow push is dropped, read of empty RX is ignored
        for (int i = 1; i <= DEPTH; i++) begin
            v = '{wr: 1'b1, data: 8'(i), rd: 1'b0, exp_full: (i == DEPTH), exp_empty: 1'b1, exp_busy: 1'b0};
            tbl.push_back(v);
        end
        tbl.push_back('{wr: 1'b1, data: 8'hEE, rd: 1'b0, exp_full: 1'b1, exp_empty: 1'b1, exp_busy: 1'b0});
        tbl.push_back('{wr: 1'b0, data: 8'h00, rd: 1'b1, exp_full: 1'b1, exp_empty: 1'b1, exp_busy: 1'b0});
        tbl.push_back('{wr: 1'b0, data: 8'h00, rd: 1'b0, exp_full: 1'b1, exp_empty: 1'b1, exp_busy: 1'b0});

        tb_clear();
        ticks(2);
        chk_reset("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            tx_wr   = tbl[i].wr;
            tx_data = tbl[i].data;
            rx_rd   = tbl[i].rd;
            tick();
            tx_wr = 1'b0;
            rx_rd = 1'b0;
            chk($sformatf("tbl%0d_tx_full", i), tx_full, tbl[i].exp_full);
            chk($sformatf("tbl%0d_rx_empty", i), rx_empty, tbl[i].exp_empty);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
        end
        chk("tbl_no_start", st_cyc.size(), 0);

        // burst: echo slave drains the full TX FIFO
        slave_on = 1'b1;
        slave_mask = 8'h00;
        slave_lat = 3;
        en = 1'b1;
        wait_dones(DEPTH, 400, "burst_dones");
        chk("burst_starts", st_cyc.size(), DEPTH);
        chk("burst_tx_full", tx_full, 1'b0);
        for (int i = 0; i < DEPTH && i < st_byte.size(); i++)
            chk($sformatf("burst_din%0d", i), st_byte[i], 8'(i + 1));
        for (int i = 1; i < DEPTH && i < st_cyc.size(); i++)
            chk($sformatf("burst_gap%0d", i), ((st_cyc[i] - done_cyc[i-1]) >= GAP_CYC + 3), 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("burst_rx_empty%0d", i), rx_empty, 1'b0);
            chk($sformatf("burst_rx%0d", i), rx_data, 8'(i + 1));
            pop();
        end
        chk("burst_drained", rx_empty, 1'b1);
        ticks(10);

        // single byte with config isolation during WAIT
        tb_clear();
        slave_lat = 20;
        slave_mask = 8'h93 ^ 8'h8A;
        cfg_dvsr = 16'd49;
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b0;
        s = cyc;
        push(8'h93);
        wait_starts(1, 10, "single_start");
        if (st_cyc.size() > 0) chk("single_latency", st_cyc[0] - s, 2);
        chk("single_din_m", din_m, 8'h93);
        chk("single_dvsr", dvsr, 16'd49);
        ticks(3);
        cfg_dvsr = 16'd9;
        cfg_cpol = 1'b1;
        cfg_cpha = 1'b1;
        ticks(3);
        chk("iso_busy", busy, 1'b1);
        chk("iso_dvsr_hold", dvsr, 16'd49);
        chk("iso_cpol_hold", cpol, 1'b0);
        chk("iso_cpha_hold", cpha, 1'b0);
        chk("iso_din_hold", din_m, 8'h93);
        wait_dones(1, 40, "single_done");
        chk("single_rx_empty", rx_empty, 1'b0);
        chk("single_rx_data", rx_data, 8'h8A);
        push(8'h5C);
        wait_starts(2, 20, "iso_second_start");
        chk("iso_dvsr_new", dvsr, 16'd9);
        chk("iso_cpol_new", cpol, 1'b1);
        chk("iso_cpha_new", cpha, 1'b1);
        wait_dones(2, 40, "iso_second_done");
        chk("iso_rx0", rx_data, 8'h8A);
        pop();
        chk("iso_rx1", rx_data, 8'h5C ^ 8'h19);
        pop();
        chk("iso_drained", rx_empty, 1'b1);
        ticks(10);

        // RX backpressure: full RX blocks further launches
        tb_clear();
        slave_lat = 2;
        slave_mask = 8'h00;
        for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
        wait_dones(DEPTH, 400, "bp_fill");
        push(8'hA0);
        push(8'hA1);
        ticks(60);
        chk("bp_no_start", st_cyc.size(), DEPTH);
        chk("bp_idle", busy, 1'b0);
        pop();
        ticks(60);
        chk("bp_one_more", st_cyc.size(), DEPTH + 1);
        if (st_byte.size() > DEPTH) chk("bp_byte", st_byte[DEPTH], 8'hA0);
        for (int i = 1; i <= DEPTH; i++) begin
            chk($sformatf("bp_rx%0d", i), rx_data, (i < DEPTH) ? 8'h10 + 8'(i) : 8'hA0);
            pop();
        end
        wait_dones(DEPTH + 2, 60, "bp_last_done");
        chk("bp_last_rx", rx_data, 8'hA1);
        pop();
        chk("bp_drained", rx_empty, 1'b1);
        ticks(10);

        // reset with RX half full and a byte stuck in WAIT
        tb_clear();
        slave_lat = 2;
        for (int i = 0; i < DEPTH / 2; i++) push(8'h21 + 8'(i));
        wait_dones(DEPTH / 2, 200, "rst_prefill");
        ticks(2);
        slave_on = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        wait_starts(DEPTH / 2 + 1, 20, "rst_launch");
        ticks(3);
        chk("rst_pre_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        tb_clear();
        ticks(2);
        rst = 1'b1;
        snap = st_cyc.size();
        ticks(30);
        chk("rst_no_start", st_cyc.size(), snap);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // start must drop asynchronously with rst
        push(8'h44);
        wait_starts(snap + 1, 10, "rst_async_launch");
        chk("rst_async_start_hi", start, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_async_start_lo", start, 1'b0);
        tb_clear();
        tick();
        rst = 1'b1;
        tick();

`ifdef SPI_XFER_TIMEOUT_EN
        // watchdog: no done_m for TO_CYC cycles in WAIT
        slave_on = 1'b0;
        push(8'hC3);
        wait_starts(1, 10, "to_launch");
        s = (st_cyc.size() > 0) ? st_cyc[0] : cyc;
        while (cyc < s + TO_CYC) tick();
        chk("to_err_before", err, 1'b0);
        tick();
        chk("to_err_set", err, 1'b1);
        chk("to_rx_empty", rx_empty, 1'b1);
        slave_on = 1'b1;
        slave_lat = 3;
        slave_mask = 8'h00;
        push(8'h3C);
        wait_starts(2, 30, "to_next_launch");
        chk("to_next_din", din_m, 8'h3C);
        wait_dones(1, 20, "to_next_done");
        chk("to_next_rx", rx_data, 8'h3C);
        chk("to_err_sticky", err, 1'b1);
        pop();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr", err, 1'b0);
`else
        // without the watchdog WAIT holds indefinitely and err stays low
        slave_on = 1'b0;
        push(8'hC3);
        wait_starts(1, 10, "nto_launch");
        ticks(150);
        chk("nto_busy", busy, 1'b1);
        chk("nto_err", err, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("nto_err_clr", err, 1'b0);
`endif
        do_reset();
        tick();

        // randomized traffic against the queue model
        slave_on = 1'b1;
        slave_mask = 8'h5A;
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            cfg_dvsr  = 16'($urandom);
            cfg_cpol  = 1'($urandom);
            cfg_cpha  = 1'($urandom);
            slave_lat = $urandom_range(1, 6);
            model_step(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
        end
        en = 1'b1;
        for (int i = 0; i < 400; i++) model_step(1'b0, 1'b1);
        chk("rnd_all_launched", acc_q.size(), 0);
        chk("rnd_final_rx_empty", rx_empty, 1'b1);
        chk("rnd_final_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
